// File: rtl/dmem_responder.sv
// Load/store responder: maps one byte/wyde/tetra/octa request onto a 64-bit synchronous RAM
// with MMIX big-endian lane placement. Returns right-justified, zero-extended read data.
module dmem_responder #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter logic [63:0] BASE       = 64'h0,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [63:0]           mem_address,
    input  logic [1:0]            mem_datasize,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [63:0]           mem_writedata,
    output logic [63:0]           mem_readdata,
    output logic                  mem_done,
    output logic                  bus_error,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [7:0]            ram_byteena,
    output logic                  ram_wren,
    output logic [63:0]           ram_data,
    input  logic [63:0]           ram_q
);

    typedef enum logic [2:0] {StIdle, StRdWait, StRdDone, StWrDone, StErrDone} state_e;

    state_e                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [1:0]            size_q, size_d;
    logic [2:0]            sh_q, sh_d;
    logic [63:0]           rdata_q, rdata_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            be_q, be_d;
    logic                  wren_q, wren_d;
    logic [63:0]           data_q, data_d;

    logic [2:0]  req_off;
    logic [3:0]  req_len;
    logic [2:0]  req_sh;
    logic [8:0]  len_mask;
    logic [7:0]  req_be;
    logic        in_range;
    logic [63:0] rd_shifted;
    logic [63:0] rd_mask;
    logic [63:0] rd_lanes;

    // req_sh is the lane index holding the least significant byte of the access.
    always_comb begin
        req_off = 3'd0;
        req_len = 4'd8;
        case (mem_datasize)
            2'd0: begin
                req_off = mem_address[2:0];
                req_len = 4'd1;
            end
            2'd1: begin
                req_off = mem_address[2:0] & 3'b110;
                req_len = 4'd2;
            end
            2'd2: begin
                req_off = mem_address[2:0] & 3'b100;
                req_len = 4'd4;
            end
            default: begin
                req_off = 3'd0;
                req_len = 4'd8;
            end
        endcase
        req_sh   = 3'(4'd8 - {1'b0, req_off} - req_len);
        len_mask = (9'd1 << req_len) - 9'd1;
        req_be   = len_mask[7:0] << req_sh;
        in_range = (mem_address[63:ADDR_WIDTH+3] == BASE[63:ADDR_WIDTH+3]);
    end

    always_comb begin
        rd_shifted = ram_q >> {sh_q, 3'b000};
        case (size_q)
            2'd0:    rd_mask = 64'h0000_0000_0000_00FF;
            2'd1:    rd_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    rd_mask = 64'h0000_0000_FFFF_FFFF;
            default: rd_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        rd_lanes = rd_shifted & rd_mask;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        sh_d    = sh_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        addr_d  = addr_q;
        be_d    = 8'h00;
        wren_d  = 1'b0;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (mem_read || mem_write) begin
                    if (!in_range) begin
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        state_d = StErrDone;
                        if (mem_read) rdata_d = 64'h0;
                    end else if (mem_read) begin
                        addr_d  = mem_address[ADDR_WIDTH+2:3];
                        cnt_d   = 2'(RD_LATENCY);
                        size_d  = mem_datasize;
                        sh_d    = req_sh;
                        state_d = StRdWait;
                    end else begin
                        addr_d  = mem_address[ADDR_WIDTH+2:3];
                        be_d    = req_be;
                        data_d  = mem_writedata << {req_sh, 3'b000};
                        wren_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = StWrDone;
                    end
                end
            end
            // RD_LATENCY edges until ram_q is valid, then one more edge to capture it.
            StRdWait: begin
                if (cnt_q == 2'd0) begin
                    rdata_d = rd_lanes;
                    done_d  = 1'b1;
                    state_d = StRdDone;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            StRdDone, StWrDone, StErrDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
            size_q  <= 2'd0;
            sh_q    <= 3'd0;
            rdata_q <= 64'h0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            be_q    <= 8'h00;
            wren_q  <= 1'b0;
            data_q  <= 64'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            sh_q    <= sh_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wren_q  <= wren_d;
            data_q  <= data_d;
        end
    end

    assign mem_readdata = rdata_q;
    assign mem_done     = done_q;
    assign bus_error    = err_q;
    assign ram_address  = addr_q;
    assign ram_byteena  = be_q;
    assign ram_wren     = wren_q;
    assign ram_data     = data_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: RAM model plus a byte-addressed big-endian
// reference memory, directed scenarios and randomized traffic.
module tb_dmem_responder;

    localparam int unsigned AW   = 12;
    localparam logic [63:0] BASE = 64'h0;
    localparam int unsigned RL   = 2;

    logic          clk;
    logic          reset_n;
    logic [63:0]   mem_address;
    logic [1:0]    mem_datasize;
    logic          mem_read;
    logic          mem_write;
    logic [63:0]   mem_writedata;
    logic [63:0]   mem_readdata;
    logic          mem_done;
    logic          bus_error;
    logic [AW-1:0] ram_address;
    logic [7:0]    ram_byteena;
    logic          ram_wren;
    logic [63:0]   ram_data;
    logic [63:0]   ram_q;

    int checks = 0;
    int passes = 0;

    dmem_responder #(
        .ADDR_WIDTH(AW),
        .BASE      (BASE),
        .RD_LATENCY(RL)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .mem_address  (mem_address),
        .mem_datasize (mem_datasize),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_writedata(mem_writedata),
        .mem_readdata (mem_readdata),
        .mem_done     (mem_done),
        .bus_error    (bus_error),
        .ram_address  (ram_address),
        .ram_byteena  (ram_byteena),
        .ram_wren     (ram_wren),
        .ram_data     (ram_data),
        .ram_q        (ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM with byte enables and RL-edge read latency (read-before-write).
    logic        ram_clear;
    logic [63:0] ram  [1<<AW];
    logic [63:0] pipe [RL];
    assign ram_q = pipe[RL-1];

    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] <= 64'h0;
        end else if (ram_wren) begin
            for (int i = 0; i < 8; i++)
                if (ram_byteena[i]) ram[ram_address][8*i +: 8] <= ram_data[8*i +: 8];
        end
        pipe[0] <= ram[ram_address];
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end

    int done_count = 0;
    int wren_count = 0;
    always @(posedge clk) begin
        if (mem_done) done_count <= done_count + 1;
        if (ram_wren) wren_count <= wren_count + 1;
    end

    // Reference: byte-addressed memory, lowest address holds the most significant byte.
    logic [7:0]  ref_mem [logic [63:0]];
    logic [63:0] last_rd = 64'h0;

    function automatic bit ref_in_window(input logic [63:0] addr);
        return addr[63:AW+3] == BASE[63:AW+3];
    endfunction

    function automatic logic [63:0] ref_base(input logic [63:0] addr, input logic [1:0] sz);
        int n = 1 << sz;
        return addr & ~64'(n - 1);
    endfunction

    function automatic logic [63:0] ref_read(input logic [63:0] addr, input logic [1:0] sz);
        int n = 1 << sz;
        logic [63:0] b = ref_base(addr, sz);
        logic [63:0] v = 64'h0;
        for (int i = 0; i < n; i++) begin
            v = v << 8;
            if (ref_mem.exists(b + 64'(i))) v[7:0] = ref_mem[b + 64'(i)];
        end
        return v;
    endfunction

    task automatic ref_write(input logic [63:0] addr, input logic [1:0] sz, input logic [63:0] d);
        int n = 1 << sz;
        logic [63:0] b = ref_base(addr, sz);
        for (int i = 0; i < n; i++) ref_mem[b + 64'(i)] = d[8*(n-1-i) +: 8];
    endtask

    function automatic logic [7:0] ref_be(input logic [63:0] addr, input logic [1:0] sz);
        int n = 1 << sz;
        int off = int'(addr[2:0]) & ~(n - 1);
        logic [7:0] be = 8'h00;
        for (int i = 0; i < n; i++) be[7-(off+i)] = 1'b1;
        return be;
    endfunction

    function automatic logic [63:0] ref_lanes(input logic [63:0] addr, input logic [1:0] sz,
                                              input logic [63:0] d);
        int n = 1 << sz;
        int off = int'(addr[2:0]) & ~(n - 1);
        logic [63:0] v = 64'h0;
        for (int i = 0; i < n; i++) v[8*(7-(off+i)) +: 8] = d[8*(n-1-i) +: 8];
        return v;
    endfunction

    function automatic logic [63:0] lane_mask(input logic [7:0] be);
        logic [63:0] m = 64'h0;
        for (int i = 0; i < 8; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    // Observations of the most recent access.
    logic [63:0]   o_rdata;
    int            o_cycles;
    logic          o_err;
    logic          o_wren;
    logic [7:0]    o_be;
    logic [AW-1:0] o_ra;
    logic [63:0]   o_data;
    logic          o_done_after;
    logic          o_wren_after;

    // Starts at posedge+1; o_cycles counts edges from request to visible mem_done (accept = 1).
    task automatic do_access(input bit rd, input bit wr, input logic [63:0] addr,
                             input logic [1:0] sz, input logic [63:0] wdata);
        mem_read      = rd;
        mem_write     = wr;
        mem_address   = addr;
        mem_datasize  = sz;
        mem_writedata = wdata;
        o_cycles = 0;
        do begin
            @(posedge clk);
            #1;
            o_cycles++;
        end while (!mem_done && o_cycles < 20);
        if (!mem_done) o_cycles = 99;
        o_rdata = mem_readdata;
        o_err   = bus_error;
        o_wren  = ram_wren;
        o_be    = ram_byteena;
        o_ra    = ram_address;
        o_data  = ram_data;
        @(posedge clk);
        #1;
        o_done_after = mem_done;
        o_wren_after = ram_wren;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if ({mem_done, bus_error, ram_wren} !== 3'b000) begin
            $display("FAIL reset_strobes: got %b want 000", {mem_done, bus_error, ram_wren});
        end else passes++;
        checks++;
        if ({mem_readdata, ram_data, ram_byteena, ram_address} !== '0) begin
            $display("FAIL reset_buses: got rd=%h data=%h be=%h ra=%h want all 0",
                     mem_readdata, ram_data, ram_byteena, ram_address);
        end else passes++;
    endtask

    task automatic test_octa_write;
        do_access(1'b0, 1'b1, 64'h100, 2'd3, 64'h0123_4567_89AB_CDEF);
        ref_write(64'h100, 2'd3, 64'h0123_4567_89AB_CDEF);
        checks++;
        if (o_cycles !== 1) $display("FAIL wr_latency: got %0d want 1", o_cycles);
        else passes++;
        checks++;
        if ({o_wren, o_be, o_ra} !== {1'b1, 8'hFF, 12'h020}) begin
            $display("FAIL wr_octa_ctrl: got wren=%b be=%h ra=%h want 1 ff 020", o_wren, o_be, o_ra);
        end else passes++;
        checks++;
        if (o_data !== 64'h0123_4567_89AB_CDEF) begin
            $display("FAIL wr_octa_data: got %h want 0123456789abcdef", o_data);
        end else passes++;
        checks++;
        if ({o_done_after, o_wren_after} !== 2'b00) begin
            $display("FAIL wr_pulse_len: got done=%b wren=%b want 0 0", o_done_after, o_wren_after);
        end else passes++;
    endtask

    task automatic test_byte_write_octa_read;
        do_access(1'b0, 1'b1, 64'h103, 2'd0, 64'h0000_0000_0000_00AB);
        ref_write(64'h103, 2'd0, 64'hAB);
        checks++;
        if ({o_be, o_data[39:32]} !== {8'h10, 8'hAB}) begin
            $display("FAIL wr_byte_lane: got be=%h lane=%h want 10 ab", o_be, o_data[39:32]);
        end else passes++;
        do_access(1'b1, 1'b0, 64'h100, 2'd3, 64'h0);
        last_rd = 64'h0123_45AB_89AB_CDEF;
        checks++;
        if (o_rdata !== 64'h0123_45AB_89AB_CDEF) begin
            $display("FAIL rd_octa: got %h want 012345ab89abcdef", o_rdata);
        end else passes++;
        checks++;
        if (o_cycles !== RL + 2) $display("FAIL rd_latency: got %0d want %0d", o_cycles, RL + 2);
        else passes++;
        checks++;
        if (o_done_after !== 1'b0) $display("FAIL rd_pulse_len: got %b want 0", o_done_after);
        else passes++;
    endtask

    task automatic test_subword_reads;
        logic [63:0] addrs [3];
        logic [1:0]  sizes [3];
        logic [63:0] want  [3];
        addrs = '{64'h105, 64'h106, 64'h107};
        sizes = '{2'd1, 2'd2, 2'd0};
        want  = '{64'h89AB, 64'h89AB_CDEF, 64'hEF};
        for (int i = 0; i < 3; i++) begin
            do_access(1'b1, 1'b0, addrs[i], sizes[i], 64'h0);
            last_rd = want[i];
            checks++;
            if (o_rdata !== want[i] || ref_read(addrs[i], sizes[i]) !== want[i]) begin
                $display("FAIL rd_subword_%0d: got %h want %h", i, o_rdata, want[i]);
            end else passes++;
        end
    endtask

    task automatic test_back_to_back;
        int d0;
        int w0;
        do_access(1'b0, 1'b1, 64'h108, 2'd3, 64'hFEDC_BA98_7654_3210);
        ref_write(64'h108, 2'd3, 64'hFEDC_BA98_7654_3210);
        d0 = done_count;
        w0 = wren_count;
        do_access(1'b1, 1'b0, 64'h100, 2'd3, 64'h0);
        checks++;
        if (o_rdata !== ref_read(64'h100, 2'd3)) begin
            $display("FAIL b2b_first: got %h want %h", o_rdata, ref_read(64'h100, 2'd3));
        end else passes++;
        do_access(1'b1, 1'b0, 64'h10A, 2'd1, 64'h0);
        last_rd = ref_read(64'h10A, 2'd1);
        checks++;
        if (o_rdata !== 64'hBA98) $display("FAIL b2b_second: got %h want ba98", o_rdata);
        else passes++;
        checks++;
        if (done_count - d0 !== 2) $display("FAIL b2b_done_count: got %0d want 2", done_count - d0);
        else passes++;
        // Both strobes high: the read wins and nothing is written.
        do_access(1'b1, 1'b1, 64'h108, 2'd2, 64'h1111_1111_1111_1111);
        last_rd = 64'hFEDC_BA98;
        checks++;
        if ({o_rdata, wren_count - w0} !== {64'hFEDC_BA98, 32'd0}) begin
            $display("FAIL read_wins: got rd=%h writes=%0d want fedcba98 0", o_rdata, wren_count - w0);
        end else passes++;
    endtask

    task automatic test_out_of_range;
        int w0 = wren_count;
        do_access(1'b1, 1'b0, 64'h8000, 2'd3, 64'h0);
        last_rd = 64'h0;
        checks++;
        if ({o_cycles, o_err, o_rdata} !== {32'd1, 1'b1, 64'h0}) begin
            $display("FAIL oor_read: got cyc=%0d err=%b rd=%h want 1 1 0", o_cycles, o_err, o_rdata);
        end else passes++;
        do_access(1'b0, 1'b1, 64'h8000, 2'd3, 64'hDEAD_BEEF_DEAD_BEEF);
        checks++;
        if ({o_cycles, o_err, o_done_after} !== {32'd1, 1'b1, 1'b0}) begin
            $display("FAIL oor_write: got cyc=%0d err=%b after=%b want 1 1 0",
                     o_cycles, o_err, o_done_after);
        end else passes++;
        checks++;
        if (wren_count - w0 !== 0) $display("FAIL oor_no_wren: got %0d want 0", wren_count - w0);
        else passes++;
        do_access(1'b1, 1'b0, 64'h0, 2'd3, 64'h0);
        last_rd = ref_read(64'h0, 2'd3);
        checks++;
        if ({o_rdata, o_err} !== {ref_read(64'h0, 2'd3), 1'b0}) begin
            $display("FAIL oor_alias: got %h err=%b want %h 0", o_rdata, o_err, ref_read(64'h0, 2'd3));
        end else passes++;
    endtask

    task automatic test_reset_in_rd_wait;
        int d0;
        mem_read     = 1'b1;
        mem_write    = 1'b0;
        mem_address  = 64'h100;
        mem_datasize = 2'd3;
        @(posedge clk);
        #1;
        @(posedge clk);
        #3;
        d0 = done_count;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({mem_done, bus_error, ram_wren, mem_readdata, ram_data, ram_byteena, ram_address} !== '0) begin
            $display("FAIL async_reset: got done=%b rd=%h ra=%h want all 0",
                     mem_done, mem_readdata, ram_address);
        end else passes++;
        mem_read = 1'b0;
        last_rd  = 64'h0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (done_count !== d0) $display("FAIL reset_no_done: got %0d want %0d", done_count, d0);
        else passes++;
        do_access(1'b0, 1'b1, 64'h1F4, 2'd2, 64'hCAFE_F00D);
        ref_write(64'h1F4, 2'd2, 64'hCAFE_F00D);
        checks++;
        if ({o_cycles, o_wren, o_be} !== {32'd1, 1'b1, 8'h0F}) begin
            $display("FAIL post_reset_write: got cyc=%0d wren=%b be=%h want 1 1 0f",
                     o_cycles, o_wren, o_be);
        end else passes++;
        do_access(1'b1, 1'b0, 64'h1F4, 2'd2, 64'h0);
        last_rd = 64'hCAFE_F00D;
        checks++;
        if (o_rdata !== 64'hCAFE_F00D) $display("FAIL post_reset_read: got %h want cafef00d", o_rdata);
        else passes++;
    endtask

    task automatic test_random;
        for (int it = 0; it < 300; it++) begin
            bit          rd   = $urandom_range(0, 1) == 1;
            logic [1:0]  sz   = 2'($urandom_range(0, 3));
            logic [63:0] addr = 64'($urandom_range(0, 511));
            logic [63:0] wd   = {$urandom, $urandom};
            bit          ok;
            int          want_cyc;
            if ($urandom_range(0, 9) == 0) addr = addr | (64'h1 << $urandom_range(15, 63));
            ok       = ref_in_window(addr);
            want_cyc = (rd && ok) ? RL + 2 : 1;
            do_access(rd, !rd, addr, sz, wd);
            checks++;
            if ({o_cycles, o_err} !== {want_cyc, !ok}) begin
                $display("FAIL rnd_timing_%0d: got cyc=%0d err=%b want %0d %b",
                         it, o_cycles, o_err, want_cyc, !ok);
            end else passes++;
            if (rd) begin
                last_rd = ok ? ref_read(addr, sz) : 64'h0;
                checks++;
                if (o_rdata !== last_rd) begin
                    $display("FAIL rnd_read_%0d: addr=%h sz=%0d got %h want %h",
                             it, addr, sz, o_rdata, last_rd);
                end else passes++;
            end else if (ok) begin
                checks++;
                if ({o_wren, o_be} !== {1'b1, ref_be(addr, sz)} ||
                    (o_data & lane_mask(o_be)) !== ref_lanes(addr, sz, wd)) begin
                    $display("FAIL rnd_write_%0d: addr=%h sz=%0d got be=%h data=%h want be=%h lanes=%h",
                             it, addr, sz, o_be, o_data, ref_be(addr, sz), ref_lanes(addr, sz, wd));
                end else passes++;
                ref_write(addr, sz, wd);
            end
            checks++;
            if (mem_readdata !== last_rd) begin
                $display("FAIL rnd_hold_%0d: got %h want %h", it, mem_readdata, last_rd);
            end else passes++;
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        ram_clear     = 1'b1;
        mem_address   = 64'h0;
        mem_datasize  = 2'd0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_writedata = 64'h0;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        ram_clear = 1'b0;
        reset_n   = 1'b1;
        @(posedge clk);
        #1;
        test_octa_write;
        test_byte_write_octa_read;
        test_subword_reads;
        test_back_to_back;
        test_out_of_range;
        test_reset_in_rd_wait;
        test_random;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish want finish before 1ms");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Memory-side responder for the execution unit's load/store request interface (mem_address/mem_datasize/mem_read/mem_write/mem_done). It accepts one sub-word or octa request at a time and maps it onto a 64-bit-wide synchronous on-chip RAM with byte enables. It applies MMIX big-endian lane placement and alignment, returns read data right-justified and zero-extended, and signals completion with a one-cycle mem_done pulse.

Parameters:
ADDR_WIDTH, 12, octabyte word-address bits of the RAM (RAM holds 2^ADDR_WIDTH octas)
BASE, 64'h0, byte base address of the RAM window; bits [ADDR_WIDTH+2:0] ignored
RD_LATENCY, 1, edges from ram_address presented to ram_q valid (1..3)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
mem_address  in  64  byte address from initiator
mem_datasize  in  2  0 byte, 1 wyde, 2 tetra, 3 octa
mem_read  in  1  read request level, held until mem_done
mem_write  in  1  write request level, held until mem_done
mem_writedata  in  64  store data, right-justified
mem_readdata  out  64  load data, right-justified, zero-extended
mem_done  out  1  one-cycle completion pulse
bus_error  out  1  one-cycle pulse with mem_done for an out-of-window access
ram_address  out  ADDR_WIDTH  octa word address
ram_byteena  out  8  bit i enables ram_data[8i+7:8i]
ram_wren  out  1  write strobe
ram_data  out  64  lane-placed write data
ram_q  in  64  RAM read data

Behaviour:
- Interface: clk and reset_n are fixed as stated in Ports. reset_n is asynchronous, active-low.
- Reset: all outputs 0. State IDLE. Latched request cleared. Reset during any state aborts the access; no mem_done is issued afterwards.
- All outputs are registered.
- States: IDLE, RD_WAIT, RD_DONE, WR_DONE, ERR_DONE.
- IDLE: on a clock edge with mem_read or mem_write high, accept the request. If both are high, the read wins.
  - Latch address, size, write data and op at the accept edge. Later changes on the request inputs are ignored until done.
- Window check: the request is in range iff mem_address[63:ADDR_WIDTH+3] == BASE[63:ADDR_WIDTH+3]. ram_address = mem_address[ADDR_WIDTH+2:3].
- Alignment: offset a = mem_address[2:0], masked by size (wyde a&6, tetra a&4, octa 0).
- Big-endian lanes: byte offset k occupies ram bits [8(7-k)+7 : 8(7-k)].
  - byteena: byte 1<<(7-a); wyde 2'b11<<(6-a); tetra 4'hF<<(4-a); octa 8'hFF.
- Write (in range): at the accept edge, drive ram_wren=1, byteena, ram_data and mem_done=1 for exactly the following cycle, then go to WR_DONE.
  - ram_data = mem_writedata's low bytes shifted into the selected lanes; other lanes are don't-care.
  - Next edge: wren=0, done=0, return to IDLE.
  - Write latency is 1 cycle.
- Read (in range): at the accept edge, drive ram_address and go to RD_WAIT, counting RD_LATENCY edges.
  - On the edge after ram_q becomes valid, load mem_readdata with the selected lanes shifted to bit 0 and upper bits zeroed. Pulse mem_done for one cycle (RD_DONE), then return to IDLE.
  - mem_done is asserted RD_LATENCY+1 cycles after the accept edge.
  - mem_readdata holds its value until the next read completes.
- Out of range: no RAM access, ram_wren stays 0. Go to ERR_DONE with mem_done=1, bus_error=1 and, for a read, mem_readdata=0, for one cycle. Then return to IDLE.
- No re-accept: the initiator still holds the request during the mem_done cycle. The responder is never in IDLE during that cycle, so the request is not sampled twice.
  - A request present in the cycle after mem_done is a new request and is accepted normally, giving back-to-back throughput.
- Read then write to the same address (CSWAP) is handled as two independent requests. The read observes the RAM contents from before the write.
- Sign extension is not performed here; the initiator does it.

Test Plan:
1. Octa write 0x0123456789ABCDEF to 0x100 -> one cycle later: ram_wren=1, ram_address=0x20, byteena=0xFF, mem_done=1; then both 0.
2. Byte write 0xAB to 0x103, then octa read 0x100 -> byteena=0x10, ram_data[39:32]=0xAB; the read returns 0x012345AB89ABCDEF with done RD_LATENCY+1 cycles after accept.
3. After scenario 1: wyde read at 0x105 -> 0x89AB; tetra read at 0x106 -> 0x89ABCDEF; byte read at 0x107 -> 0xEF. Upper bits are zero in each case.
4. Read held high through its mem_done, followed immediately by a second read at another address -> exactly two mem_done pulses with correct data each; no duplicate access.
5. Out of range: ADDR_WIDTH=12, BASE=0, read at 0x8000 -> mem_done and bus_error high the next cycle, mem_readdata=0, ram_wren never asserted. Same for a write.
6. reset_n asserted in RD_WAIT -> all outputs 0 asynchronously, state IDLE, no mem_done after release; a following write completes normally.
